// File: rtl/axi_wr_pkg.sv
// Shared definitions for the two-requester AXI3 write arbiter:
// FSM state encoding and the fixed AW attributes driven to the master port.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    // 4-byte beats, incrementing bursts, unprivileged secure data, bufferable/modifiable
    localparam logic [2:0] AXI_SIZE  = 3'b010;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_CACHE = 4'b0011;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: when both request, the one not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI3 write master between two requesters, one whole burst
// (AW, all W beats, B) at a time; WLAST is regenerated from the latched AWLEN.
module axi_wr_arbiter
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,

    input  logic [ADDR_W-1:0]     r0_awaddr,
    input  logic [3:0]            r0_awlen,
    input  logic                  r0_awvalid,
    input  logic [DATA_W-1:0]     r0_wdata,
    input  logic [DATA_W/8-1:0]   r0_wstrb,
    input  logic                  r0_wlast,
    input  logic                  r0_wvalid,
    input  logic                  r0_bready,
    output logic                  r0_awready,
    output logic                  r0_wready,
    output logic                  r0_bvalid,
    output logic [1:0]            r0_bresp,

    input  logic [ADDR_W-1:0]     r1_awaddr,
    input  logic [3:0]            r1_awlen,
    input  logic                  r1_awvalid,
    input  logic [DATA_W-1:0]     r1_wdata,
    input  logic [DATA_W/8-1:0]   r1_wstrb,
    input  logic                  r1_wlast,
    input  logic                  r1_wvalid,
    input  logic                  r1_bready,
    output logic                  r1_awready,
    output logic                  r1_wready,
    output logic                  r1_bvalid,
    output logic [1:0]            r1_bresp,

    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [3:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [2:0]            m_awprot,
    output logic [3:0]            m_awcache,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,

    output logic [1:0]            grant,
    output logic                  len_err
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  grant_q;
    logic        last_q;
    logic [3:0]  beat_cnt;
    logic [3:0]  len_q;
    logic        len_err_q;
    logic [1:0]  rr_gnt;
    logic        sel;
    logic        wlast_gen;
    logic        req_wlast;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    rr_arb2 u_rr (
        .req        ({r1_awvalid, r0_awvalid}),
        .last_grant (last_q),
        .gnt        (rr_gnt)
    );

    assign sel       = grant_q[1];
    assign grant     = grant_q;
    assign len_err   = len_err_q;

    assign m_awaddr  = sel ? r1_awaddr : r0_awaddr;
    assign m_awlen   = sel ? r1_awlen  : r0_awlen;
    assign m_wdata   = sel ? r1_wdata  : r0_wdata;
    assign m_wstrb   = sel ? r1_wstrb  : r0_wstrb;
    assign req_wlast = sel ? r1_wlast  : r0_wlast;

    assign m_awsize  = AXI_SIZE;
    assign m_awburst = AXI_BURST;
    assign m_awprot  = AXI_PROT;
    assign m_awcache = AXI_CACHE;

    assign wlast_gen = (beat_cnt == len_q);
    assign m_wlast   = (state == DATA) && wlast_gen;

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the owner's handshake signals are connected; everything else reads 0.
    always_comb begin
        state_nxt  = state;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        r0_awready = 1'b0;
        r0_wready  = 1'b0;
        r0_bvalid  = 1'b0;
        r0_bresp   = 2'b00;
        r1_awready = 1'b0;
        r1_wready  = 1'b0;
        r1_bvalid  = 1'b0;
        r1_bresp   = 2'b00;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        b_hs       = 1'b0;
        case (state)
            IDLE: begin
                if (r0_awvalid || r1_awvalid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_awvalid  = sel ? r1_awvalid : r0_awvalid;
                r0_awready = !sel && m_awready;
                r1_awready = sel && m_awready;
                aw_hs      = m_awvalid && m_awready;
                if (aw_hs) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_wvalid  = sel ? r1_wvalid : r0_wvalid;
                r0_wready = !sel && m_wready;
                r1_wready = sel && m_wready;
                w_hs      = m_wvalid && m_wready;
                if (w_hs && wlast_gen) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                r0_bvalid = !sel && m_bvalid;
                r1_bvalid = sel && m_bvalid;
                r0_bresp  = sel ? 2'b00 : m_bresp;
                r1_bresp  = sel ? m_bresp : 2'b00;
                m_bready  = sel ? r1_bready : r0_bready;
                b_hs      = m_bvalid && m_bready;
                if (b_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            beat_cnt  <= 4'd0;
            len_q     <= 4'd0;
            len_err_q <= 1'b0;
        end else begin
            if (state == IDLE && rr_gnt != 2'b00) begin
                grant_q <= rr_gnt;
            end
            if (aw_hs) begin
                beat_cnt <= 4'd0;
                len_q    <= m_awlen;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 4'd1;
                if (req_wlast != wlast_gen) begin
                    len_err_q <= 1'b1;
                end
            end
            if (b_hs) begin
                grant_q <= 2'b00;
                last_q  <= sel;
            end
        end
    end

endmodule
